// File: rtl/fifo_rd_upsizer_pkg.sv
// Shared enums for the stream-adapter blocks.
// The read-side upsizer alternates between assembling a beat and presenting it.
package fifo_rd_upsizer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } upsz_state_e;

endpackage

// File: rtl/fifo_rd_upsizer.sv
// Pops a narrow FIFO and packs RATIO words (lane 0 first) into one wide valid/ready beat.
// A flush closes a partial beat early so the tail of a transfer can drain.
module fifo_rd_upsizer
  import fifo_rd_upsizer_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int RATIO     = 4,
  parameter int OUT_WIDTH = IN_WIDTH * RATIO,
  parameter int CNT_WIDTH = $clog2(RATIO)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 flush_i,
  input  logic                 fifo_empty_i,
  input  logic [IN_WIDTH-1:0]  fifo_data_i,
  output logic                 fifo_pop_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic [RATIO-1:0]     strb_o,
  output logic                 busy_o
);

  if (RATIO < 2) begin : g_ratio_chk
    $error("fifo_rd_upsizer: RATIO must be >= 2");
  end

  localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(RATIO - 1);

  upsz_state_e          r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [OUT_WIDTH-1:0] r_data;
  logic [RATIO-1:0]     r_strb;
  logic                 r_flush_pend;

  logic                 w_run;
  logic                 w_close;
  logic                 w_pop;
  logic [OUT_WIDTH-1:0] w_lane_mask;

  function automatic logic [RATIO-1:0] fill_mask(input logic [CNT_WIDTH-1:0] n);
    logic [RATIO-1:0] m;
    m = '0;
    for (int k = 0; k < RATIO; k++) m[k] = (k < int'(n));
    return m;
  endfunction

  // Reset and clear both suppress the pop so no word is lost in that cycle.
  assign w_run   = rst_ni & ~clr_i;
  assign w_close = (r_state == FILL) & (flush_i | r_flush_pend) & (r_cnt != '0);

  always_comb begin
    w_pop = 1'b0;
    if (w_run && !fifo_empty_i) begin
      if (r_state == FILL) w_pop = ~w_close;
      else                 w_pop = ready_i & ~r_flush_pend;
    end
  end

  always_comb begin
    w_lane_mask = '0;
    for (int k = 0; k < RATIO; k++) w_lane_mask[k*IN_WIDTH +: IN_WIDTH] = {IN_WIDTH{r_strb[k]}};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      r_state      <= FILL;
      r_cnt        <= '0;
      r_data       <= '0;
      r_strb       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          // A pending flush is consumed here: it either closes the beat or is dropped at cnt 0.
          r_flush_pend <= 1'b0;
          if (w_close) begin
            r_state <= HOLD;
            r_strb  <= fill_mask(r_cnt);
            r_cnt   <= '0;
          end else if (w_pop) begin
            r_data[int'(r_cnt)*IN_WIDTH +: IN_WIDTH] <= fifo_data_i;
            if (r_cnt == LAST_LANE) begin
              r_state <= HOLD;
              r_strb  <= '1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
          end
        end
        HOLD: begin
          if (flush_i) r_flush_pend <= 1'b1;
          if (ready_i) begin
            r_state <= FILL;
            r_strb  <= '0;
            r_data  <= '0;
            // Back-to-back: the first word of the next beat lands while this one is accepted.
            if (w_pop) r_data[IN_WIDTH-1:0] <= fifo_data_i;
            r_cnt <= w_pop ? CNT_WIDTH'(1) : '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign fifo_pop_o = w_pop;
  assign valid_o    = (r_state == HOLD);
  assign strb_o     = r_strb;
  assign data_o     = r_data & w_lane_mask;
  assign busy_o     = (r_cnt != '0) | valid_o;

endmodule

// File: tb/tb_fifo_rd_upsizer.sv
// Directed bench for fifo_rd_upsizer (IN_WIDTH=8, RATIO=4) with a queue-backed FIFO model
// and a random empty/ready soak checked against the pushed word order.
module tb_fifo_rd_upsizer;

  logic        clk = 1'b0;
  logic        rst_ni, clr_i, flush_i, fifo_empty_i, ready_i;
  logic [7:0]  fifo_data_i;
  logic        fifo_pop_o, valid_o, busy_o;
  logic [31:0] data_o;
  logic [3:0]  strb_o;

  int total = 0;
  int bad   = 0;
  int npop  = 0;
  int npop0;
  int cyc;
  logic       hide = 1'b0;
  logic [7:0] q[$];
  logic [7:0] sw[$];
  logic [35:0] bq[$];
  logic [7:0] w;

  fifo_rd_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i), .flush_i(flush_i),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_pop_o(fifo_pop_o),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .strb_o(strb_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty_i = hide || (q.size() == 0);
    fifo_data_i  = (q.size() == 0) ? 8'h00 : q[0];
  endtask

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    refresh();
  endtask

  task automatic tick();
    logic p;
    #1;
    p = fifo_pop_o;
    chk("pop_when_empty", {63'd0, p & fifo_empty_i}, 64'd0);
    if (valid_o && ready_i) bq.push_back({strb_o, data_o});
    @(posedge clk);
    #1;
    if (p) begin
      void'(q.pop_front());
      npop++;
    end
    refresh();
  endtask

  initial begin
    rst_ni = 1'b0; clr_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    refresh();
    push(8'h55);

    // reset held 3 cycles with FIFO non-empty
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pop", {63'd0, fifo_pop_o}, 64'd0);
    end
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_strb", {60'd0, strb_o}, 64'd0);
    chk("rst_data", {32'd0, data_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_npop", npop, 0);
    q.delete(); refresh();
    rst_ni = 1'b1;
    tick();

    // full beat
    ready_i = 1'b1;
    bq.delete();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int i = 0; i < 3; i++) tick();
    chk("full_valid_early", {63'd0, valid_o}, 64'd0);
    tick();
    chk("full_valid", {63'd0, valid_o}, 64'd1);
    chk("full_data", {32'd0, data_o}, 64'h44332211);
    chk("full_strb", {60'd0, strb_o}, 64'hF);
    tick();
    chk("full_nbeats", bq.size(), 1);
    chk("full_beat", {28'd0, bq[0]}, {28'd0, 4'hF, 32'h44332211});
    chk("full_idle", {62'd0, valid_o, busy_o}, 64'd0);

    // back-pressure then streaming
    ready_i = 1'b0;
    bq.delete();
    for (int i = 1; i <= 12; i++) push(8'(i));
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", {32'd0, data_o}, 64'h04030201);
      chk("stall_strb", {60'd0, strb_o}, 64'hF);
      chk("stall_pop", {63'd0, fifo_pop_o}, 64'd0);
      tick();
    end
    ready_i = 1'b1;
    npop0 = npop;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("stream_pop", {63'd0, fifo_pop_o}, 64'd1);
      tick();
    end
    chk("stream_npop", npop - npop0, 8);
    tick();
    chk("stream_nbeats", bq.size(), 3);
    if (bq.size() == 3) begin
      chk("stream_b0", {28'd0, bq[0]}, {28'd0, 4'hF, 32'h04030201});
      chk("stream_b1", {28'd0, bq[1]}, {28'd0, 4'hF, 32'h08070605});
      chk("stream_b2", {28'd0, bq[2]}, {28'd0, 4'hF, 32'h0C0B0A09});
    end

    // flush of a partial beat, then flush at cnt 0
    bq.delete();
    push(8'hAA); push(8'hBB);
    tick(); tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_valid", {63'd0, valid_o}, 64'd1);
    chk("flush_data", {32'd0, data_o}, 64'h0000BBAA);
    chk("flush_strb", {60'd0, strb_o}, 64'h3);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    chk("flush0_valid", {63'd0, valid_o}, 64'd0);
    chk("flush0_nbeats", bq.size(), 1);

    // flush while a full beat waits
    ready_i = 1'b0;
    bq.delete();
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    for (int i = 0; i < 4; i++) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    push(8'hCC); push(8'hDD);
    ready_i = 1'b1;
    #1;
    chk("hold_pend_nopop", {63'd0, fifo_pop_o}, 64'd0);
    tick();
    #1;
    chk("pend_cnt0_pop", {63'd0, fifo_pop_o}, 64'd1);
    tick(); tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("hflush_data", {32'd0, data_o}, 64'h0000DDCC);
    chk("hflush_strb", {60'd0, strb_o}, 64'h3);
    tick();
    chk("hflush_nbeats", bq.size(), 2);
    if (bq.size() == 2) begin
      chk("hflush_b0", {28'd0, bq[0]}, {28'd0, 4'hF, 32'h64636261});
      chk("hflush_b1", {28'd0, bq[1]}, {28'd0, 4'h3, 32'h0000DDCC});
    end

    // clear mid-assembly
    bq.delete();
    push(8'h71); push(8'h72); push(8'h73); push(8'h74);
    tick(); tick(); tick();
    chk("clr_busy_before", {63'd0, busy_o}, 64'd1);
    clr_i = 1'b1;
    #1;
    chk("clr_pop", {63'd0, fifo_pop_o}, 64'd0);
    tick();
    clr_i = 1'b0;
    chk("clr_busy", {63'd0, busy_o}, 64'd0);
    chk("clr_valid", {63'd0, valid_o}, 64'd0);
    push(8'h81); push(8'h82); push(8'h83);
    for (int i = 0; i < 4; i++) tick();
    chk("clr_next_data", {32'd0, data_o}, 64'h83828174);
    tick();
    chk("clr_nbeats", bq.size(), 1);

    // random empty/ready soak
    bq.delete();
    sw.delete();
    for (int i = 0; i < 40; i++) begin
      w = 8'($urandom);
      sw.push_back(w);
      push(w);
    end
    cyc = 0;
    while (bq.size() < 10 && cyc < 600) begin
      ready_i = ($urandom_range(0, 3) != 0);
      hide    = ($urandom_range(0, 3) == 0);
      refresh();
      tick();
      cyc++;
    end
    hide = 1'b0;
    refresh();
    chk("soak_nbeats", bq.size(), 10);
    for (int b = 0; b < 10; b++) begin
      if (b < bq.size())
        chk("soak_beat", {28'd0, bq[b]},
            {28'd0, 4'hF, sw[4*b+3], sw[4*b+2], sw[4*b+1], sw[4*b]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
